// File: rtl/icache_pkg.sv
// Shared widths, tag-entry layout and controller state encoding for the I-cache tag path.
package icache_pkg;

   localparam int ADDR_W   = 32;
   localparam int INDEX_W  = 8;
   localparam int OFFSET_W = 4;
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
   } tag_entry_t;

   typedef enum logic [2:0] {
      SWEEP,
      IDLE,
      LOOKUP,
      MISS,
      FILL,
      UPDATE
   } state_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/icache_tag_ctrl.sv
// Direct-mapped I-cache tag sequencer: lookup, miss refill handshake, tag update and
// invalidate-all sweep after reset or flush.
module icache_tag_ctrl
   import icache_pkg::*;
#(
   parameter int ADDR_WIDTH   = ADDR_W,
   parameter int INDEX_WIDTH  = INDEX_W,
   parameter int OFFSET_WIDTH = OFFSET_W
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       req_valid,
   output logic                                       req_ready,
   input  logic [ADDR_WIDTH-1:0]                      req_addr,
   output logic                                       resp_valid,
   output logic                                       resp_hit,
   output logic                                       refill_req,
   output logic [ADDR_WIDTH-1:0]                      refill_addr,
   input  logic                                       refill_ack,
   input  logic                                       refill_done,
   input  logic                                       flush_req,
   output logic                                       flush_busy,
   output logic [31:0]                                hit_cnt,
   output logic [31:0]                                miss_cnt,
   output logic [INDEX_WIDTH-1:0]                     tag_rd_addr,
   input  logic [ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH:0] tag_rd_data,
   output logic [INDEX_WIDTH-1:0]                     tag_wr_addr,
   output logic [ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH:0] tag_wr_data,
   output logic                                       tag_wr_en
);

   localparam int TAG_WIDTH  = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int LINE_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;
   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;

   state_t                  state_q, state_d;
   logic [INDEX_WIDTH-1:0]  sweep_q, sweep_d;
   logic [LINE_WIDTH-1:0]   line_q, line_d;
   logic                    flush_pend_q, flush_pend_d;
   logic [31:0]             hit_cnt_q, hit_cnt_d;
   logic [31:0]             miss_cnt_q, miss_cnt_d;

   logic [INDEX_WIDTH-1:0]  reg_idx;
   logic [TAG_WIDTH-1:0]    reg_tag;
   logic                    lookup_hit;
   logic                    unused_offset;

   // Only the line address is kept; the byte offset never influences the tag path.
   assign unused_offset = ^req_addr[OFFSET_WIDTH-1:0];

   assign reg_idx     = line_q[INDEX_WIDTH-1:0];
   assign reg_tag     = line_q[LINE_WIDTH-1 -: TAG_WIDTH];
   assign lookup_hit  = tag_rd_data[TAG_WIDTH] && (tag_rd_data[TAG_WIDTH-1:0] == reg_tag);

   assign tag_rd_addr = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
   assign refill_addr = {line_q, {OFFSET_WIDTH{1'b0}}};
   assign flush_busy  = (state_q == SWEEP);
   assign hit_cnt     = hit_cnt_q;
   assign miss_cnt    = miss_cnt_q;

   always_comb begin
      state_d      = state_q;
      sweep_d      = sweep_q;
      line_d       = line_q;
      flush_pend_d = flush_pend_q | (flush_req && (state_q != SWEEP));
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      resp_hit     = 1'b0;
      refill_req   = 1'b0;
      tag_wr_en    = 1'b0;
      tag_wr_addr  = reg_idx;
      tag_wr_data  = '0;

      case (state_q)
         SWEEP: begin
            tag_wr_en   = 1'b1;
            tag_wr_addr = sweep_q;
            sweep_d     = sweep_q + 1'b1;
            if (sweep_q == LAST_IDX) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (flush_pend_q) begin
               state_d      = SWEEP;
               sweep_d      = '0;
               flush_pend_d = 1'b0;
            end else begin
               req_ready = 1'b1;
               if (req_valid) begin
                  line_d  = req_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
                  state_d = LOOKUP;
               end
            end
         end
         LOOKUP: begin
            if (lookup_hit) begin
               resp_valid = 1'b1;
               resp_hit   = 1'b1;
               hit_cnt_d  = sat_inc32(hit_cnt_q);
               req_ready  = !flush_pend_q;
               // Pipelined hits: a new accept re-arms the lookup without passing through IDLE.
               if (req_valid && !flush_pend_q) begin
                  line_d = req_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
               end else begin
                  state_d = IDLE;
               end
            end else begin
               miss_cnt_d = sat_inc32(miss_cnt_q);
               state_d    = MISS;
            end
         end
         MISS: begin
            refill_req = 1'b1;
            if (refill_ack) begin
               state_d = FILL;
            end
         end
         FILL: begin
            if (refill_done) begin
               state_d = UPDATE;
            end
         end
         UPDATE: begin
            tag_wr_en   = 1'b1;
            tag_wr_data = {1'b1, reg_tag};
            resp_valid  = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = SWEEP;
            sweep_d = '0;
         end
      endcase

      // Keep the RAM untouched while reset is held.
      if (!rst_n) begin
         tag_wr_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= SWEEP;
         sweep_q      <= '0;
         line_q       <= '0;
         flush_pend_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         line_q       <= line_d;
         flush_pend_q <= flush_pend_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Randomized bench for icache_tag_ctrl: tag RAM model plus a transaction-level cache
// reference (valid/tag per line, hit/miss counts).
module tb_icache_tag_ctrl;
   import icache_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [31:0]   req_addr = '0;
   logic          resp_valid;
   logic          resp_hit;
   logic          refill_req;
   logic [31:0]   refill_addr;
   logic          refill_ack = 1'b0;
   logic          refill_done = 1'b0;
   logic          flush_req = 1'b0;
   logic          flush_busy;
   logic [31:0]   hit_cnt;
   logic [31:0]   miss_cnt;
   logic [7:0]    tag_rd_addr;
   logic [20:0]   tag_rd_data;
   logic [7:0]    tag_wr_addr;
   logic [20:0]   tag_wr_data;
   logic          tag_wr_en;

   icache_tag_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .resp_valid  (resp_valid),
      .resp_hit    (resp_hit),
      .refill_req  (refill_req),
      .refill_addr (refill_addr),
      .refill_ack  (refill_ack),
      .refill_done (refill_done),
      .flush_req   (flush_req),
      .flush_busy  (flush_busy),
      .hit_cnt     (hit_cnt),
      .miss_cnt    (miss_cnt),
      .tag_rd_addr (tag_rd_addr),
      .tag_rd_data (tag_rd_data),
      .tag_wr_addr (tag_wr_addr),
      .tag_wr_data (tag_wr_data),
      .tag_wr_en   (tag_wr_en)
   );

   always #5 clk = ~clk;

   // Tag RAM: registered read address, write on the same clock.
   logic [20:0] ram [256];
   always @(posedge clk) begin
      tag_rd_data <= ram[tag_rd_addr];
      if (tag_wr_en) ram[tag_wr_addr] <= tag_wr_data;
   end

   tag_entry_t  mdl [256];
   int unsigned exp_hits = 0;
   int unsigned exp_misses = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) mdl[i] = '0;
   endtask

   function automatic logic model_hit(input logic [31:0] a);
      tag_entry_t e;
      e = mdl[a[11:4]];
      return e.valid && (e.tag == a[31:12]);
   endfunction

   task automatic chk_counters();
      chk("hit_cnt", hit_cnt, 64'(exp_hits));
      chk("miss_cnt", miss_cnt, 64'(exp_misses));
   endtask

   // Entered at a negedge where the sweep is about to write entry 0.
   task automatic sweep_check();
      for (int i = 0; i < 256; i++) begin
         #1 chk("sweep", {tag_wr_en, flush_busy, tag_wr_addr, tag_wr_data},
                {1'b1, 1'b1, 8'(i), 21'h0});
         @(negedge clk);
      end
      #1 chk("sweep_end", {flush_busy, req_ready}, 2'b01);
      model_clear();
   endtask

   task automatic do_reset(input int ncyc);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (ncyc) @(negedge clk);
      #1 chk("rst_outs", {req_ready, resp_valid, resp_hit, refill_req, tag_wr_en, flush_busy},
             6'b000001);
      chk("rst_refill_addr", refill_addr, 0);
      exp_hits = 0;
      exp_misses = 0;
      chk_counters();
      rst_n = 1'b1;
      sweep_check();
   endtask

   task automatic wait_ready();
      int w = 0;
      #1;
      while (!req_ready && w < 300) begin
         @(negedge clk);
         #1;
         w++;
      end
      chk("req_ready", req_ready, 1);
   endtask

   // One lookup from IDLE; ends at a negedge (+1) with the controller back in IDLE.
   task automatic do_access(input logic [31:0] a, input bit flush_in_fill);
      bit exp_hit = model_hit(a);
      tag_entry_t e;
      req_valid = 1'b1;
      req_addr  = a;
      wait_ready();
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (exp_hit) begin
         chk("hit_resp", {resp_valid, resp_hit}, 2'b11);
         exp_hits++;
      end else begin
         chk("miss_lookup", {resp_valid, req_ready}, 2'b00);
         exp_misses++;
         @(negedge clk);
         #1 chk("refill_req", {refill_req, refill_addr}, {1'b1, a & 32'hFFFF_FFF0});
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            #1 chk("refill_hold", refill_req, 1);
         end
         refill_ack = 1'b1;
         @(negedge clk);
         refill_ack = 1'b0;
         #1 chk("refill_drop", refill_req, 0);
         if (flush_in_fill) begin
            flush_req = 1'b1;
            @(negedge clk);
            flush_req = 1'b0;
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         refill_done = 1'b1;
         @(negedge clk);
         refill_done = 1'b0;
         #1 chk("update", {resp_valid, resp_hit, tag_wr_en, tag_wr_addr, tag_wr_data},
                {1'b1, 1'b0, 1'b1, a[11:4], 1'b1, a[31:12]});
         e.valid = 1'b1;
         e.tag   = a[31:12];
         mdl[a[11:4]] = e;
      end
      @(negedge clk);
      #1 chk_counters();
      if (flush_in_fill) begin
         chk("flush_wins", {req_ready, flush_busy}, 2'b00);
         @(negedge clk);
         sweep_check();
      end
   endtask

   // Two back-to-back lookups expected to hit.
   task automatic do_hit_pair(input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1;
      req_addr  = a;
      wait_ready();
      @(negedge clk);
      req_addr = b;
      #1 chk("pair_a", {resp_valid, resp_hit, req_ready}, {model_hit(a), model_hit(a), 1'b1});
      exp_hits++;
      @(negedge clk);
      req_valid = 1'b0;
      #1 chk("pair_b", {resp_valid, resp_hit}, {model_hit(b), model_hit(b)});
      exp_hits++;
      @(negedge clk);
      #1 chk_counters();
   endtask

   function automatic logic [31:0] rand_addr();
      logic [7:0]  idx;
      logic [19:0] tag;
      case ($urandom_range(0, 2))
         0:       idx = 8'h23;
         1:       idx = 8'h24;
         default: idx = 8'h7F;
      endcase
      tag = 20'($urandom_range(1, 3));
      return {tag, idx, 4'($urandom_range(0, 15))};
   endfunction

   initial begin
      #500_000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   initial begin
      model_clear();
      do_reset(3);

      do_access(32'h0000_1230, 1'b0);
      chk("cold_miss_cnt", miss_cnt, 1);
      do_hit_pair(32'h0000_123C, 32'h0000_1234);
      chk("pair_hit_cnt", hit_cnt, 2);

      do_access(32'h0000_2230, 1'b0);
      do_access(32'h0000_1230, 1'b0);

      do_access(32'h0000_2230, 1'b1);
      do_access(32'h0000_2230, 1'b0);
      chk("post_flush_miss", miss_cnt, 5);

      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = rand_addr();
         if (model_hit(a) && ($urandom_range(0, 3) == 0)) begin
            do_hit_pair(a, a ^ 32'h0000_0004);
         end else begin
            do_access(a, 1'b0);
         end
      end

      // Reset while a refill is outstanding and unacknowledged.
      req_valid = 1'b1;
      req_addr  = 32'h0000_5990;
      wait_ready();
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #1 chk("rst_miss_req", refill_req, 1);
      do_reset(1);
      do_access(32'h0000_1230, 1'b0);
      chk("after_rst_miss", miss_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
